// File: rtl/board_input_debounce_pkg.sv
// ---------------------------------------------------------------------------
// board_input_debounce_pkg
//   Shared board constants for the input conditioner.
//   - DEBOUNCE_CYCLES_DEFAULT : stable cycles needed to accept a new level
//                               (10 ms at the 10 MHz core clock).
//   - KEY_ACTIVE_LEVEL        : electrical level of a pressed push-button.
//   - cnt_width()             : width of a stability counter for a given
//                               debounce length (never less than 1 bit).
// ---------------------------------------------------------------------------
package board_input_debounce_pkg;

   localparam int   DEBOUNCE_CYCLES_DEFAULT = 100000;
   localparam logic KEY_ACTIVE_LEVEL        = 1'b0;

   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : board_input_debounce_pkg

// File: rtl/board_input_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//   One input pin: 2-flop synchronizer, stability counter and accepted-state
//   flop. A new level is accepted only after DEBOUNCE_CYCLES consecutive
//   cycles of disagreement with the accepted state.
//
//   Ports
//     clock      : core clock, all state on posedge
//     reset      : synchronous, active-high
//     raw        : asynchronous pin
//     idle_value : pin level at rest; synchronizer and accepted flop reset
//                  to it, and level is reported relative to it
//     level      : debounced state, 1 = pin away from its idle value
//     edge_pulse : one-cycle pulse on every accepted transition
// ---------------------------------------------------------------------------
module debounce_channel
   import board_input_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   input  logic idle_value,
   output logic level,
   output logic edge_pulse
);

   localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          acc_q,   acc_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          pulse_q, pulse_d;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      if (sync_q[1] == acc_q) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         acc_d   = sync_q[1];
         cnt_d   = '0;
         pulse_d = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values, exactly like the hardware.
      if (reset) begin
         sync_q  <= {2{idle_value}};
         acc_q   <= idle_value;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], raw};
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   // Accepted state is held in pin polarity; the XOR turns it into an
   // active-high level (this is where active-low keys get inverted).
   assign level      = acc_q ^ idle_value;
   assign edge_pulse = pulse_q;

endmodule : debounce_channel

// File: rtl/board_input_debounce.sv
// ---------------------------------------------------------------------------
// board_input_debounce
//   Conditions DE1-SoC push-buttons and slide switches into the core clock
//   domain: per-pin synchronize + debounce, then clean levels, edge pulses,
//   sticky key-press flags with acknowledge, and a registered interrupt.
//
//   Ports
//     clock, reset : core clock, synchronous active-high reset
//     key_raw      : raw buttons, 0 = pressed
//     sw_raw       : raw switches
//     key_ack      : per-key clear strobe for key_pending
//     key_level    : debounced buttons, 1 = pressed
//     key_press    : one-cycle pulse on accepted press
//     key_release  : one-cycle pulse on accepted release
//     key_pending  : sticky press flag, cleared by key_ack
//     sw_level     : debounced switches
//     sw_change    : one-cycle pulse on any accepted switch transition
//     irq          : registered OR of key_pending
// ---------------------------------------------------------------------------
module board_input_debounce
   import board_input_debounce_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter int N_SW            = 10,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_raw,
   input  logic [N_SW-1:0]   sw_raw,
   input  logic [N_KEYS-1:0] key_ack,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_pending,
   output logic [N_SW-1:0]   sw_level,
   output logic [N_SW-1:0]   sw_change,
   output logic              irq
);

   logic [N_KEYS-1:0] key_edge;
   logic [N_KEYS-1:0] sticky_q, sticky_d;
   logic              irq_q;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
         .clock      (clock),
         .reset      (reset),
         .raw        (key_raw[i]),
         .idle_value (~KEY_ACTIVE_LEVEL),
         .level      (key_level[i]),
         .edge_pulse (key_edge[i])
      );
   end

   for (genvar i = 0; i < N_SW; i++) begin : g_sw
      debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
         .clock      (clock),
         .reset      (reset),
         .raw        (sw_raw[i]),
         .idle_value (1'b0),
         .level      (sw_level[i]),
         .edge_pulse (sw_change[i])
      );
   end

   // Level and pulse update on the same edge, so the new level tells the
   // direction of the accepted transition.
   assign key_press   = key_edge &  key_level;
   assign key_release = key_edge & ~key_level;

   // The press pulse is merged in combinationally so pending rises on the
   // same edge as key_press; the sticky flop holds it afterwards. An ack
   // during the press cycle loses against the set term.
   assign sticky_d    = (sticky_q & ~key_ack) | key_press;
   assign key_pending = sticky_q | key_press;

   always_ff @(posedge clock) begin
      if (reset) begin
         sticky_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
         irq_q    <= |key_pending;
      end
   end

   assign irq = irq_q;

endmodule : board_input_debounce

// File: tb/tb_board_input_debounce.sv
module tb_board_input_debounce;

   localparam int NK = 4;
   localparam int NS = 10;
   localparam int DC = 8;

   logic          clock;
   logic          reset;
   logic [NK-1:0] key_raw;
   logic [NS-1:0] sw_raw;
   logic [NK-1:0] key_ack;
   logic [NK-1:0] key_level, key_press, key_release, key_pending;
   logic [NS-1:0] sw_level, sw_change;
   logic          irq;

   board_input_debounce #(
      .N_KEYS(NK), .N_SW(NS), .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .key_raw     (key_raw),
      .sw_raw      (sw_raw),
      .key_ack     (key_ack),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_pending (key_pending),
      .sw_level    (sw_level),
      .sw_change   (sw_change),
      .irq         (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Number of rising edges so far; read at the falling edge after edge n.
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int            cyc;
      logic [NK-1:0] press;
      logic [NK-1:0] rel;
      logic [NK-1:0] lvl;
      logic [NK-1:0] pend;
      logic [NS-1:0] chg;
      logic [NS-1:0] swl;
   } exp_t;

   exp_t sb[$];

   task automatic expect_ev(input int c, input logic [NK-1:0] press, input logic [NK-1:0] rel,
                            input logic [NK-1:0] lvl, input logic [NK-1:0] pend,
                            input logic [NS-1:0] chg, input logic [NS-1:0] swl);
      exp_t e;
      e.cyc = c; e.press = press; e.rel = rel; e.lvl = lvl;
      e.pend = pend; e.chg = chg; e.swl = swl;
      sb.push_back(e);
   endtask

   // Monitor: every cycle with a pulse on any output consumes one expected event.
   always @(negedge clock) begin
      if ((|key_press) || (|key_release) || (|sw_change)) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {key_press, key_release, sw_change}, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pulse_cycle", cyc,         e.cyc);
            check("key_press",   key_press,   e.press);
            check("key_release", key_release, e.rel);
            check("sw_change",   sw_change,   e.chg);
            check("key_level",   key_level,   e.lvl);
            check("sw_level",    sw_level,    e.swl);
            check("key_pending", key_pending, e.pend);
         end
      end
   end

   // Advance to the falling edge that follows rising edge n.
   task automatic at(input int n);
      if (cyc > n) check("schedule", cyc, n);
      while (cyc < n) @(negedge clock);
   endtask

   initial begin
      reset   = 1'b1;
      key_raw = 4'hF;
      sw_raw  = '0;
      key_ack = '0;
      @(negedge clock);

      // Reset state
      at(20);
      check("rst_key_level",   key_level,   0);
      check("rst_key_pending", key_pending, 0);
      check("rst_sw_level",    sw_level,    0);
      check("rst_irq",         irq,         0);
      check("rst_pulses", {key_press, key_release, sw_change}, 0);
      reset = 1'b0;
      at(30);
      check("idle_key_level", key_level, 0);
      check("idle_irq",       irq,       0);

      // Clean press on key 0: visible 10 edges after the first sampling edge
      key_raw[0] = 1'b0;
      expect_ev(40, 4'b0001, 4'b0000, 4'b0001, 4'b0001, '0, '0);
      at(40);
      check("irq_lag", irq, 0);
      at(41);
      check("irq_set",      irq,         1);
      check("pending_key0", key_pending, 4'b0001);

      // Key 1 bounces with 7-cycle low runs (one short of acceptance)
      at(50);
      for (int i = 0; i < 3; i++) begin
         key_raw[1] = 1'b0;
         at(cyc + 7);
         key_raw[1] = 1'b1;
         at(cyc + 1);
      end
      check("bounce_no_level", key_level, 4'b0001);
      key_raw[1] = 1'b0;                       // final stable low at cycle 74
      expect_ev(84, 4'b0010, 4'b0000, 4'b0011, 4'b0011, '0, '0);

      // Ack keys 0/1, plus key 3 which is not pending
      at(90);
      key_ack = 4'b1011;
      at(91);
      key_ack = '0;
      check("ack_clear_01", key_pending, 0);
      check("irq_still_1",  irq,         1);
      at(92);
      check("irq_clear_01", irq, 0);

      // Key 2 press, then plain ack
      key_raw[2] = 1'b0;
      expect_ev(102, 4'b0100, 4'b0000, 4'b0111, 4'b0100, '0, '0);
      at(103);
      check("pending_key2", key_pending, 4'b0100);
      check("irq_key2",     irq,         1);
      at(105);
      key_ack = 4'b0100;
      at(106);
      key_ack = '0;
      check("ack_clear_2", key_pending, 0);
      at(107);
      check("irq_clear_2", irq, 0);

      // Key 2 release, then press with coincident ack
      key_raw[2] = 1'b1;
      expect_ev(117, 4'b0000, 4'b0100, 4'b0011, 4'b0000, '0, '0);
      at(120);
      key_raw[2] = 1'b0;
      expect_ev(130, 4'b0100, 4'b0000, 4'b0111, 4'b0100, '0, '0);
      at(130);
      key_ack = 4'b0100;                       // same cycle as key_press[2]
      at(131);
      key_ack = '0;
      check("set_wins", key_pending, 4'b0100);
      at(132);
      check("set_wins_hold", key_pending, 4'b0100);
      check("set_wins_irq",  irq,         1);
      key_ack = 4'b0100;
      at(133);
      key_ack = '0;
      check("ack_after_set", key_pending, 0);

      // Reset at counter=5 during key 3 press
      at(140);
      key_raw[3] = 1'b0;
      at(147);
      reset = 1'b1;
      at(148);
      reset = 1'b0;
      check("midrst_level",   key_level,   0);
      check("midrst_pending", key_pending, 0);
      check("midrst_irq",     irq,         0);
      expect_ev(158, 4'b1111, 4'b0000, 4'b1111, 4'b1111, '0, '0);
      at(157);
      check("midrst_restart", key_level, 0);

      // Release all keys
      at(170);
      key_raw = 4'hF;
      expect_ev(180, 4'b0000, 4'b1111, 4'b0000, 4'b1111, '0, '0);
      at(185);
      key_ack = 4'hF;
      at(186);
      key_ack = '0;
      check("ack_all", key_pending, 0);

      // Switches high out of reset, then one switch drops
      at(190);
      reset  = 1'b1;
      sw_raw = 10'h3FF;
      at(195);
      reset = 1'b0;
      expect_ev(205, '0, '0, '0, '0, 10'h3FF, 10'h3FF);
      at(210);
      sw_raw[3] = 1'b0;
      expect_ev(220, '0, '0, '0, '0, 10'h008, 10'h3F7);
      at(235);
      check("sw_level_final", sw_level, 10'h3F7);
      check("events_left",    sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_board_input_debounce
